// File: rtl/wide_add_sequencer_if.sv
// Request/response bundle for wide_add_sequencer.
// Purpose: carries the wide-operand request handshake, the result handshake,
// and the aggregate NZCV flags between a requester and the sequencer.
// Signals:
//   in_valid/in_ready   : operation request handshake
//   A_wide/B_wide       : operands, word k = bits [k*N +: N]
//   C_in/sub            : carry-in for add, subtract select
//   out_valid/out_ready : result handshake
//   R_wide              : full-width result
//   N/Z/C/V_flag        : aggregate flags of the full-width result
//   busy                : sequencer is not idle
interface wide_add_sequencer_if #(
  parameter int N     = 32,
  parameter int WORDS = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [N*WORDS-1:0]   A_wide;
  logic [N*WORDS-1:0]   B_wide;
  logic                 C_in;
  logic                 sub;
  logic                 out_valid;
  logic                 out_ready;
  logic [N*WORDS-1:0]   R_wide;
  logic                 N_flag;
  logic                 Z_flag;
  logic                 C_flag;
  logic                 V_flag;
  logic                 busy;

  modport master (
    output in_valid, A_wide, B_wide, C_in, sub, out_ready,
    input  in_ready, out_valid, R_wide, N_flag, Z_flag, C_flag, V_flag, busy
  );

  modport slave (
    input  in_valid, A_wide, B_wide, C_in, sub, out_ready,
    output in_ready, out_valid, R_wide, N_flag, Z_flag, C_flag, V_flag, busy
  );
endinterface

// File: rtl/wide_add_sequencer.sv
// Wide add/subtract sequencer.
// Purpose: performs an N*WORDS-bit add or subtract by feeding one N-bit
// scalar adder one word per cycle, least-significant word first, chaining
// the carry between cycles and forming NZCV for the whole result.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : wide_add_sequencer_if slave (request, result, flags, busy)

// N-bit scalar adder with NZCV flags.
// Ports: A, B operands; C_in carry-in; R sum; N/Z/C/V flags of this word.
module adder #(
  parameter int N = 32
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         C_in,
  output logic [N-1:0] R,
  output logic         N_flag,
  output logic         Z_flag,
  output logic         C_flag,
  output logic         V_flag
);
  logic [N:0] sum;

  assign sum    = {1'b0, A} + {1'b0, B} + {{N{1'b0}}, C_in};
  assign R      = sum[N-1:0];
  assign C_flag = sum[N];
  assign N_flag = sum[N-1];
  assign Z_flag = (sum[N-1:0] == '0);
  // Overflow: operands share a sign that the result does not.
  assign V_flag = (A[N-1] == B[N-1]) && (sum[N-1] != A[N-1]);
endmodule

module wide_add_sequencer #(
  parameter int N     = 32,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  wide_add_sequencer_if.slave  bus
);
  localparam int W     = N * WORDS;
  localparam int IDX_W = $clog2(WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [W-1:0]       r_q, r_d;
  logic               cy_q, cy_d;
  logic               zacc_q, zacc_d;
  logic               n_q, n_d;
  logic               z_q, z_d;
  logic               c_q, c_d;
  logic               v_q, v_d;
  logic               vld_q, vld_d;

  logic [N-1:0]       a_word;
  logic [N-1:0]       b_word;
  logic [N-1:0]       add_r;
  logic               add_n;
  logic               add_z;
  logic               add_c;
  logic               add_v;
  logic               last_word;

  assign a_word    = a_q[idx_q*N +: N];
  assign b_word    = b_q[idx_q*N +: N];
  assign last_word = (idx_q == IDX_W'(WORDS-1));

  adder #(.N(N)) u_adder (
    .A      (a_word),
    .B      (b_word),
    .C_in   (cy_q),
    .R      (add_r),
    .N_flag (add_n),
    .Z_flag (add_z),
    .C_flag (add_c),
    .V_flag (add_v)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    cy_d    = cy_q;
    zacc_d  = zacc_q;
    n_d     = n_q;
    z_d     = z_q;
    c_d     = c_q;
    v_d     = v_q;
    vld_d   = vld_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.A_wide;
          // Subtract is A + ~B + 1: invert B once here, seed carry with 1.
          b_d     = bus.sub ? ~bus.B_wide : bus.B_wide;
          cy_d    = bus.sub | bus.C_in;
          zacc_d  = 1'b1;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        r_d[idx_q*N +: N] = add_r;
        cy_d   = add_c;
        zacc_d = zacc_q & add_z;
        if (last_word) begin
          // Sign, carry and overflow belong to the top word only.
          n_d     = add_n;
          c_d     = add_c;
          v_d     = add_v;
          z_d     = zacc_q & add_z;
          vld_d   = 1'b1;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      r_q     <= '0;
      cy_q    <= 1'b0;
      zacc_q  <= 1'b0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      r_q     <= r_d;
      cy_q    <= cy_d;
      zacc_q  <= zacc_d;
      n_q     <= n_d;
      z_q     <= z_d;
      c_q     <= c_d;
      v_q     <= v_d;
      vld_q   <= vld_d;
    end
  end

  // Latched operands are only meaningful after an accept, so they need no reset.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = vld_q;
  assign bus.R_wide    = r_q;
  assign bus.N_flag    = n_q;
  assign bus.Z_flag    = z_q;
  assign bus.C_flag    = c_q;
  assign bus.V_flag    = v_q;
  assign bus.busy      = (state_q != IDLE);
endmodule
